// File: rtl/scu_dsp_dma_if.sv
// scu_dsp_dma_if: beat handshake and data path between the DMA engine and the A/B-bus arbiter.
interface scu_dsp_dma_if #(parameter int DATA_W = 32);
    logic CE_R, ACK, END, REQ, LAST;
    logic [DATA_W-1:0] BUS_DI, BUS_DO;
    modport master(input CE_R, ACK, END, BUS_DI, output REQ, LAST, BUS_DO);
    modport slave(output CE_R, ACK, END, BUS_DI, input REQ, LAST, BUS_DO);
endinterface

// File: rtl/scu_dsp_dma_engine.sv
// scu_dsp_dma_engine: SCU DSP DMA engine owning the per-bank CT counters; moves words bus<->data RAM or bus->program RAM.
// Define SCU_DSP_DMA_HOLD_EN to honour HOLD (keep the RAM address fixed); otherwise counters always advance.
module scu_dsp_dma_engine #(
    parameter int BANKS = 4,
    parameter int DEPTH_W = 6,
    parameter int DATA_W = 32,
    parameter int CNT_W = 8,
    parameter int PRG_W = 8
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       CE,
    input  logic                       START,
    input  logic                       DIR,
    input  logic                       PRGW,
    input  logic [$clog2(BANKS)-1:0]   BANK,
    input  logic                       HOLD,
    input  logic [CNT_W-1:0]           CNT,
    input  logic                       ABORT,
    input  logic [BANKS-1:0]           CT_LD,
    input  logic [BANKS-1:0]           CT_INC,
    input  logic [DEPTH_W-1:0]         CT_VAL,
    output logic [BANKS*DEPTH_W-1:0]   CT,
    input  logic [BANKS*DATA_W-1:0]    RAM_Q,
    output logic [DATA_W-1:0]          RAM_D,
    output logic [BANKS-1:0]           RAM_WE,
    output logic [PRG_W-1:0]           PRG_ADDR,
    output logic                       PRG_WE,
    output logic                       BUSY,
    output logic                       DONE,
    scu_dsp_dma_if.master              bus
);
    localparam int BW = $clog2(BANKS);
    typedef enum logic [1:0] {IDLE, REQ_ST, END_ST, FIN} state_t;
    state_t state;
    logic dir_q, prg_q, end_q, hold_q, beat;
    logic [BW-1:0] bank_q;
    logic [CNT_W:0] rem;
    logic [BANKS-1:0][DEPTH_W-1:0] ct;
`ifndef SCU_DSP_DMA_HOLD_EN
    logic unused_hold;
    assign unused_hold = HOLD;
    assign hold_q = 1'b0;
`endif
    assign beat = state == REQ_ST && bus.ACK && bus.CE_R;
    assign bus.REQ = state == REQ_ST;
    assign bus.LAST = rem == 1'b1;
    assign bus.BUS_DO = RAM_Q[bank_q*DATA_W +: DATA_W];
    assign BUSY = state != IDLE;
    assign CT = ct;
    assign RAM_D = bus.BUS_DI;
    assign RAM_WE = beat && !dir_q && !prg_q ? BANKS'(1) << bank_q : '0;
    assign PRG_WE = beat && prg_q;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            dir_q <= 1'b0;
            prg_q <= 1'b0;
            end_q <= 1'b0;
            bank_q <= '0;
            rem <= '0;
            ct <= '0;
            PRG_ADDR <= '0;
            DONE <= 1'b0;
`ifdef SCU_DSP_DMA_HOLD_EN
            hold_q <= 1'b0;
`endif
        end else begin
            end_q <= bus.END;
            DONE <= 1'b0;
            // sequencer load beats sequencer increment beats DMA advance; never summed
            for (int i = 0; i < BANKS; i++)
                if (CE && CT_LD[i]) ct[i] <= CT_VAL;
                else if (CE && CT_INC[i]) ct[i] <= ct[i] + 1'b1;
                else if (beat && !prg_q && !hold_q && bank_q == BW'(i)) ct[i] <= ct[i] + 1'b1;
            if (beat && prg_q) PRG_ADDR <= PRG_ADDR + 1'b1;
            if (beat) rem <= rem - 1'b1;
            case (state)
                IDLE: if (START && CE) begin
                    state <= REQ_ST;
                    dir_q <= DIR && !PRGW;
                    prg_q <= PRGW;
                    bank_q <= BANK;
                    rem <= {~|CNT, CNT};
                    if (PRGW) PRG_ADDR <= '0;
`ifdef SCU_DSP_DMA_HOLD_EN
                    hold_q <= HOLD;
`endif
                end
                REQ_ST: if (beat && rem == 1'b1) state <= END_ST;
                END_ST: if (end_q && !bus.END) state <= FIN;
                FIN: if (CE) begin
                    state <= IDLE;
                    DONE <= 1'b1;
                end
            endcase
            // an accepted beat in the abort cycle has already committed above
            if (ABORT && state != IDLE) begin
                state <= IDLE;
                rem <= '0;
                DONE <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_scu_dsp_dma_engine.sv
// tb_scu_dsp_dma_engine: scoreboard bench; expected beats are queued at drive time and matched by a negedge monitor.
`timescale 1ns/1ps
module tb_scu_dsp_dma_engine;
    logic CLK, RST_N, CE, START, DIR, PRGW, HOLD, ABORT;
    logic [1:0] BANK;
    logic [7:0] CNT;
    logic [3:0] CT_LD, CT_INC;
    logic [5:0] CT_VAL;
    logic [23:0] CT;
    logic [127:0] RAM_Q;
    logic [31:0] RAM_D;
    logic [3:0] RAM_WE;
    logic [7:0] PRG_ADDR;
    logic PRG_WE, BUSY, DONE;
    scu_dsp_dma_if #(.DATA_W(32)) bus();

    scu_dsp_dma_engine dut (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .START(START), .DIR(DIR), .PRGW(PRGW),
        .BANK(BANK), .HOLD(HOLD), .CNT(CNT), .ABORT(ABORT), .CT_LD(CT_LD),
        .CT_INC(CT_INC), .CT_VAL(CT_VAL), .CT(CT), .RAM_Q(RAM_Q), .RAM_D(RAM_D),
        .RAM_WE(RAM_WE), .PRG_ADDR(PRG_ADDR), .PRG_WE(PRG_WE), .BUSY(BUSY),
        .DONE(DONE), .bus(bus)
    );

    int n_tests = 0, n_fail = 0, done_cnt = 0;
    int cur_bank = 0, rem_m = 0;
    logic cur_dir = 0, cur_prg = 0, cur_hold = 0;
    logic [5:0] ct_m [4];
    logic [7:0] prg_m = 0;
    logic [31:0] mem [4][64];
    logic [63:0] sb [$];
    logic [63:0] obs;

    initial CLK = 0;
    always #5 CLK = ~CLK;

    always_comb
        for (int b = 0; b < 4; b++) RAM_Q[b*32 +: 32] = mem[b][CT[b*6 +: 6]];

    always @(posedge CLK)
        for (int b = 0; b < 4; b++) if (RAM_WE[b]) mem[b][CT[b*6 +: 6]] <= RAM_D;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (DONE) done_cnt++;
        if ((bus.REQ && bus.ACK && bus.CE_R) || PRG_WE || |RAM_WE) begin
            obs = {18'h0, PRG_WE, bus.LAST, RAM_WE, PRG_WE ? PRG_ADDR : {2'b0, CT[cur_bank*6 +: 6]},
                   (PRG_WE || |RAM_WE) ? RAM_D : bus.BUS_DO};
            if (sb.size() == 0) check("sb_unexpected", obs, 64'h0);
            else check("beat", obs, sb.pop_front());
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_ct(input string tag);
        check(tag, 64'(CT), 64'({ct_m[3], ct_m[2], ct_m[1], ct_m[0]}));
    endtask

    task automatic load_ct(input int b, input logic [5:0] v);
        CE = 1; CT_LD = 4'(1) << b; CT_VAL = v;
        cyc();
        CE = 0; CT_LD = 0;
        ct_m[b] = v;
    endtask

    task automatic start(input logic d, input logic p, input logic [1:0] b, input logic h, input logic [7:0] c);
        CE = 1; START = 1; DIR = d; PRGW = p; BANK = b; HOLD = h; CNT = c;
        cyc();
        CE = 0; START = 0;
        cur_bank = int'(b); cur_dir = d && !p; cur_prg = p;
`ifdef SCU_DSP_DMA_HOLD_EN
        cur_hold = h;
`else
        cur_hold = 0;
`endif
        rem_m = c == 0 ? 256 : int'(c);
        if (p) prg_m = 0;
        check("busy_start", 64'(BUSY), 64'd1);
        check("req_start", 64'(bus.REQ), 64'd1);
    endtask

    task automatic beat(input logic [31:0] d);
        logic [5:0] a;
        a = ct_m[cur_bank];
        check("req_beat", 64'(bus.REQ), 64'd1);
        bus.ACK = 1; bus.CE_R = 1; bus.BUS_DI = d;
        if (cur_prg) sb.push_back({18'h0, 1'b1, rem_m == 1, 4'h0, prg_m, d});
        else if (!cur_dir) sb.push_back({18'h0, 1'b0, rem_m == 1, 4'(1) << cur_bank, 2'b0, a, d});
        else sb.push_back({18'h0, 1'b0, rem_m == 1, 4'h0, 2'b0, a, mem[cur_bank][a]});
        cyc();
        bus.ACK = 0; bus.CE_R = 0;
        rem_m--;
        if (cur_prg) prg_m++;
        else if (!cur_hold) ct_m[cur_bank]++;
    endtask

    task automatic finish();
        int d0;
        d0 = done_cnt;
        check("req_after_last", 64'(bus.REQ), 64'd0);
        bus.END = 1;
        cyc();
        check("busy_end_hi", 64'(BUSY), 64'd1);
        bus.END = 0;
        cyc();
        cyc();
        check("done_wait_ce", 64'(done_cnt - d0), 64'd0);
        CE = 1;
        cyc();
        CE = 0;
        check("done_pulse", 64'(DONE), 64'd1);
        check("busy_done", 64'(BUSY), 64'd0);
        cyc();
        check("done_single", 64'(DONE), 64'd0);
        check("done_count", 64'(done_cnt - d0), 64'd1);
        check("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        RST_N = 0; CE = 0; START = 0; DIR = 0; PRGW = 0; HOLD = 0; ABORT = 0;
        BANK = 0; CNT = 0; CT_LD = 0; CT_INC = 0; CT_VAL = 0;
        bus.ACK = 0; bus.CE_R = 0; bus.END = 0; bus.BUS_DI = 0;
        for (int b = 0; b < 4; b++) begin
            ct_m[b] = 0;
            for (int a = 0; a < 64; a++) mem[b][a] = 32'hB000_0000 | (b << 16) | a;
        end
        repeat (2) cyc();
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_req", 64'(bus.REQ), 64'd0);
        check("rst_done", 64'(DONE), 64'd0);
        check("rst_last", 64'(bus.LAST), 64'd0);
        check("rst_we", 64'({RAM_WE, PRG_WE}), 64'd0);
        check("rst_prg", 64'(PRG_ADDR), 64'd0);
        check_ct("rst_ct");
        RST_N = 1;
        cyc();
        // wrap across the top of bank 2
        load_ct(2, 6'h3E);
        start(0, 0, 2, 0, 8'd4);
        beat(32'hA); beat(32'hB); beat(32'hC); beat(32'hD);
        check_ct("ct_wrap");
        finish();
        // full-range count
        start(0, 0, 3, 0, 8'd0);
        for (int i = 0; i < 256; i++) beat(32'h1000 + i);
        check_ct("ct_256");
        finish();
        // program RAM write, with DIR=1 demoted to a write
        start(1, 1, 0, 0, 8'd3);
        beat(32'h50); beat(32'h51); beat(32'h52);
        check("prg_addr_end", 64'(PRG_ADDR), 64'd3);
        check_ct("ct_prg");
        finish();
        // RAM to bus read with hold
        load_ct(1, 6'd5);
        start(1, 0, 1, 1, 8'd3);
        beat(0); beat(0); beat(0);
        check_ct("ct_hold");
        finish();
        // sequencer increment
        CE = 1; CT_INC = 4'b1000;
        cyc();
        CE = 0; CT_INC = 0;
        ct_m[3]++;
        check_ct("ct_inc");
        // abort after two of five beats
        begin
            int d0;
            d0 = done_cnt;
            start(0, 0, 0, 0, 8'd5);
            beat(32'h61); beat(32'h62);
            ABORT = 1;
            cyc();
            ABORT = 0;
            check("abort_busy", 64'(BUSY), 64'd0);
            check("abort_req", 64'(bus.REQ), 64'd0);
            check_ct("abort_ct");
            repeat (4) cyc();
            check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        end
        // CT_LD wins over a same-cycle beat; START while busy is ignored
        start(0, 0, 0, 0, 8'd2);
        CE = 1; CT_LD = 4'b0001; CT_VAL = 6'h10;
        beat(32'h66);
        CE = 0; CT_LD = 0;
        ct_m[0] = 6'h10;
        check_ct("ct_ld_prio");
        CE = 1; START = 1; BANK = 3; CNT = 8'd7; DIR = 1;
        cyc();
        CE = 0; START = 0;
        beat(32'h77);
        check_ct("ct_after_restart");
        finish();
        // asynchronous reset mid-transfer
        start(0, 0, 2, 0, 8'd4);
        beat(32'h88);
        #2;
        RST_N = 0;
        #1;
        for (int b = 0; b < 4; b++) ct_m[b] = 0;
        check("mid_rst_busy", 64'(BUSY), 64'd0);
        check("mid_rst_req", 64'(bus.REQ), 64'd0);
        check("mid_rst_out", 64'({DONE, bus.LAST, RAM_WE, PRG_WE}), 64'd0);
        check_ct("mid_rst_ct");
        cyc();
        RST_N = 1;
        cyc();
        start(0, 0, 2, 0, 8'd2);
        beat(32'h91); beat(32'h92);
        check_ct("ct_post_rst");
        finish();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/scu_dsp_dma_engine.md
# scu_dsp_dma_engine

Parametrised DMA transfer engine for the SCU DSP. It is the successor to the DSP's built-in single-format DMA logic, and sits between the DSP sequencer and the A/B-bus DMA arbiter. It owns the per-bank data-RAM address counters (CTn) and moves words between the external bus and either one data-RAM bank or program RAM. Bank count, RAM depth, data width and count width are generic. Compared with the earlier logic it adds hold-address mode, full-range counts, abort and a done pulse.

## Interface
Parameters:
- BANKS, 4, number of data-RAM banks (≥2, power of two)
- DEPTH_W, 6, address width of each data-RAM bank
- DATA_W, 32, word width
- CNT_W, 8, transfer count width
- PRG_W, 8, program RAM address width

Ports:
- CLK  in  1  system clock
- RST_N  in  1  reset, asynchronous, active-low
- CE  in  1  DSP instruction-step enable
- CE_R  in  1  bus-side transfer strobe
- START  in  1  DMA instruction issued (qualified by CE)
- DIR  in  1  0 = bus→RAM, 1 = RAM→bus
- PRGW  in  1  target is program RAM (only legal with DIR=0)
- BANK  in  log2(BANKS)  selected data-RAM bank
- HOLD  in  1  do not advance RAM address during the transfer
- CNT  in  CNT_W  beat count; 0 means 2^CNT_W
- ABORT  in  1  cancel the active transfer
- CT_LD  in  BANKS  per-bank counter load strobes from the sequencer (qualified by CE)
- CT_INC  in  BANKS  per-bank sequencer increments (qualified by CE)
- CT_VAL  in  DEPTH_W  counter load value
- CT  out  BANKS*DEPTH_W  current counters, bank 0 in the LSBs
- BUS_DI  in  DATA_W  word from the bus
- BUS_DO  out  DATA_W  word to the bus (read data of the selected bank)
- RAM_Q  in  BANKS*DATA_W  bank read data
- RAM_D  out  DATA_W  write data (equal to BUS_DI)
- RAM_WE  out  BANKS  one-hot bank write strobe
- PRG_ADDR  out  PRG_W  program RAM write address
- PRG_WE  out  1  program RAM write strobe
- REQ  out  1  beat request to the arbiter
- ACK  in  1  beat accepted (qualified by CE_R)
- LAST  out  1  the current beat is the final beat
- END  in  1  arbiter end-of-transfer level
- BUSY  out  1  transfer active (the T0 flag)
- DONE  out  1  single-CLK completion pulse

## Operation
- State machine:
  - IDLE: START&CE → REQ_ST. Latch DIR, PRGW, BANK, HOLD. Set REM to CNT, with 0 loaded as 2^CNT_W (REM is CNT_W+1 bits). If PRGW, clear PRG_ADDR to 0.
  - REQ_ST: each beat (ACK&CE_R) decrements REM. When REM reaches 0 → END_ST.
  - END_ST: a falling edge of END (END sampled every CLK) → FIN.
  - FIN: on CE → IDLE. BUSY drops and DONE pulses for one CLK.
- Beat side effects:
  - DIR=0, PRGW=0: RAM_WE[BANK]=1.
  - PRGW=1: PRG_WE=1 at PRG_ADDR, then PRG_ADDR++.
  - DIR=1: BUS_DO is RAM_Q of BANK at CT[BANK].
  - Unless HOLD is set, CT[BANK]++ and wraps modulo 2^DEPTH_W. PRG_ADDR wraps modulo 2^PRG_W.
- Outputs:
  - REQ = (state==REQ_ST).
  - LAST = (REM==1).
  - BUSY = (state≠IDLE).
- START while BUSY is ignored; the sequencer stalls.
- CT_LD beats CT_INC, and CT_INC beats a DMA beat increment on the same bank in the same CLK; none of them accumulate. The sequencer never touches CT[BANK] while BUSY; if it does, the priority above applies.
- ABORT in any non-IDLE state: next CLK → IDLE, REQ=0, BUSY=0, no DONE, counters keep their values. An ABORT in the same CLK as a beat still commits that beat.
- PRGW with DIR=1: treated as DIR=0 to program RAM.

## Timing
- Reset values:
  - All CT = 0, PRG_ADDR = 0, REM = 0, state IDLE.
  - REQ, BUSY, DONE, LAST, RAM_WE, PRG_WE = 0.
- START at CE edge k: BUSY and REQ are high from CLK k+1.
- Write strobes are combinational (ACK&CE_R&state) and coincide with the accepted beat.
- REQ is low in the CLK after the final beat.
- Minimum transfer of one beat: START → 1 beat → END falling edge → FIN → next CE. DONE comes at least 3 CLK after START.
- The bus may wait indefinitely on ACK or END; there is no timeout.
- Reset mid-transfer: immediate return to reset values; no DONE.

## Configuration
- SCU_DSP_DMA_HOLD_EN defined: the HOLD input behaves as specified.
- Not defined: HOLD is ignored (treated as 0), the latch flop is removed, and counters always advance.

## Test plan
- BANKS=4, CT[2]=0x3E, START DIR=0 BANK=2 CNT=4, BUS_DI=A,B,C,D → RAM2 written at 0x3E, 0x3F, 0x00, 0x01; CT[2]=0x02. LAST is high only on beat 4. DONE pulses once after the END falling edge.
- CNT=0 → exactly 256 beats. REQ stays high through beat 255 and is low after beat 256.
- START PRGW=1 CNT=3 → PRG_WE at addresses 0, 1, 2; CT unchanged. DIR=1 BANK=1 HOLD=1 CNT=3 with CT[1]=5 → BUS_DO = RAM1[5] three times, CT[1] stays 5. Without SCU_DSP_DMA_HOLD_EN, CT[1] ends at 8.
- ABORT after beat 2 of 5 → BUSY=0 on the next CLK, CT advanced by 2, DONE never asserted.
- CT_LD[0] with CT_VAL=0x10 in the same CLK as a bank-0 beat → CT[0]=0x10. A START while BUSY leaves the latched REM and BANK unchanged.
- RST_N low mid-transfer → all outputs 0 and CT=0 immediately. After release, a new START works normally.
